// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master and the existing slave: FSM states,
// mode constants, default word width and a counter-width helper.
package spi_pkg;

  // Mode 0: SCLK idles low, data captured on the rising edge.
  localparam int unsigned SPI_CPOL       = 0;
  localparam int unsigned SPI_CPHA       = 0;
  localparam int unsigned SPI_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL
  } spi_state_e;

  // Width of a counter covering 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Handshake and serial-pin bundle between control logic and spi_master.
interface spi_master_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH
);

  logic                  start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  busy;
  logic                  done;
  logic                  SCLK;
  logic                  SS;
  logic                  MOSI;
  logic                  MISO;

  modport master (
    input  start, tx_data, MISO,
    output rx_data, busy, done, SCLK, SS, MOSI
  );

  modport slave (
    output start, tx_data, MISO,
    input  rx_data, busy, done, SCLK, SS, MOSI
  );

endinterface

// File: rtl/spi_master_clkgen.sv
// SCLK half-period divider: tick_o is high in the last CLK cycle of each
// CLK_DIV-cycle phase. clr_i restarts the phase on start acceptance.
module spi_master_clkgen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LastCnt = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  assign tick_o = (div_cnt_q == LastCnt);

  // Count up, wrapping at CLK_DIV-1; a clear wins over counting.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      div_cnt_d = '0;
    end
  end

  // Divide counter register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0, MSB-first SPI master exchanging one DATA_WIDTH-bit word per start.
// Optional back-to-back bursts with SS held low: define SPI_MASTER_BURST_EN.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  spi_master_if.master bus
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LastBit = BW'(DATA_WIDTH - 1);
  localparam logic SclkIdle = SPI_CPOL[0];

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  ss_q, ss_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  tick;

  spi_master_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .CLK    (CLK),
    .RESET  (RESET),
    .clr_i  (accept),
    .tick_o (tick)
  );

  assign bus.SCLK    = sclk_q;
  assign bus.SS      = ss_q;
  assign bus.MOSI    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

  // Next-state and registered-output logic; every phase lasts one tick period.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    ss_d       = ss_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          tx_shift_d = bus.tx_data;
          bit_cnt_d  = '0;
          ss_d       = 1'b0;
          mosi_d     = bus.tx_data[DATA_WIDTH-1];
          busy_d     = 1'b1;
          state_d    = LEAD;
        end
      end
      // MISO is captured on the same edge that raises SCLK.
      LEAD, LOW: begin
        if (tick) begin
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], bus.MISO};
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          sclk_d = SclkIdle;
          if (bit_cnt_q == LastBit) begin
            state_d = TRAIL;
          end else begin
            tx_shift_d = tx_shift_q << 1;
            mosi_d     = tx_shift_q[DATA_WIDTH-2];
            bit_cnt_d  = bit_cnt_q + 1'b1;
            state_d    = LOW;
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
`ifdef SPI_MASTER_BURST_EN
          if (bus.start) begin
            // Chain the next word without releasing SS.
            accept     = 1'b1;
            tx_shift_d = bus.tx_data;
            bit_cnt_d  = '0;
            mosi_d     = bus.tx_data[DATA_WIDTH-1];
            state_d    = LEAD;
          end else begin
            ss_d    = 1'b1;
            busy_d  = 1'b0;
            mosi_d  = 1'b0;
            state_d = IDLE;
          end
`else
          ss_d    = 1'b1;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= SclkIdle;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback, slave model, ignored starts,
// mid-transfer reset, CLK_DIV=1 and (when SPI_MASTER_BURST_EN) bursts.
module tb_spi_master;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  spi_master_if #(.DATA_WIDTH(8)) bus1 ();
  spi_master_if #(.DATA_WIDTH(8)) bus2 ();

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus1)
  );

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(1)) dut_div1 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus2)
  );

  int checks = 0;
  int errors = 0;

  // MISO source for dut: 0 loopback, 1 slave model, 2 constant one.
  int         miso_mode = 0;
  logic [7:0] data_to_send = 8'h00;
  logic [7:0] s_shift = 8'h00;
  logic [7:0] s_rx = 8'h00;
  logic [7:0] miso_bits = 8'h00;
  logic [7:0] mosi_bits = 8'h00;

  assign bus1.MISO = (miso_mode == 0) ? bus1.MOSI : (miso_mode == 1) ? s_shift[7] : 1'b1;
  assign bus2.MISO = 1'b1;

  // Monitor and mode-0 slave model, evaluated on the falling CLK edge.
  int   sclk_rises = 0;
  int   done_cnt = 0;
  int   ss_rises = 0;
  int   ss_run = 0;
  int   last_ss_low = 0;
  int   mosi_viol = 0;
  logic sclk_p = 1'b0;
  logic ss_p = 1'b1;
  logic mosi_p = 1'b0;
  logic [7:0] done_rx_q[$];

  always @(negedge CLK) begin
    if (ss_p && !bus1.SS) s_shift = data_to_send;
    if (!sclk_p && bus1.SCLK) begin
      sclk_rises++;
      s_rx      = {s_rx[6:0], bus1.MOSI};
      miso_bits = {miso_bits[6:0], bus1.MISO};
      mosi_bits = {mosi_bits[6:0], bus1.MOSI};
    end
    if (sclk_p && !bus1.SCLK && !bus1.SS) s_shift = s_shift << 1;
    if ((bus1.MOSI !== mosi_p) && bus1.SCLK) mosi_viol++;
    if (bus1.done) begin
      done_cnt++;
      done_rx_q.push_back(bus1.rx_data);
    end
    if (!bus1.SS) begin
      ss_run++;
    end else if (ss_run > 0) begin
      last_ss_low = ss_run;
      ss_rises++;
      ss_run = 0;
    end
    sclk_p = bus1.SCLK;
    ss_p   = bus1.SS;
    mosi_p = bus1.MOSI;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus1.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus1.start = 1'b0; bus1.tx_data = 8'h00;
    bus2.start = 1'b0; bus2.tx_data = 8'h00;
    repeat (3) tick();
    checks++; if (bus1.SS !== 1'b1) begin errors++; $display("FAIL reset_ss got %b want 1", bus1.SS); end
    checks++; if (bus1.SCLK !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", bus1.SCLK); end
    checks++; if (bus1.MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", bus1.MOSI); end
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus1.busy); end
    checks++; if (bus1.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus1.done); end
    checks++; if (bus1.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx got %h want 00", bus1.rx_data); end
    checks++; if (bus2.SS !== 1'b1) begin errors++; $display("FAIL reset_ss_div1 got %b want 1", bus2.SS); end
    RESET = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_loopback();
    bit ok;
    int r0, d0;
    miso_mode = 0;
    r0 = sclk_rises; d0 = done_cnt;
    bus1.tx_data = 8'hA5; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0; bus1.tx_data = 8'h00;
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL loop_done_timeout got 0 want 1"); end
    checks++; if (bus1.rx_data !== 8'hA5) begin errors++; $display("FAIL loop_rx got %h want a5", bus1.rx_data); end
    checks++; if (mosi_bits !== 8'hA5) begin errors++; $display("FAIL loop_mosi_bits got %h want a5", mosi_bits); end
    checks++; if (sclk_rises - r0 != 8) begin errors++; $display("FAIL loop_rises got %0d want 8", sclk_rises - r0); end
    tick();
    checks++; if (bus1.done !== 1'b0) begin errors++; $display("FAIL loop_done_width got %b want 0", bus1.done); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL loop_done_cnt got %0d want 1", done_cnt - d0); end
    checks++; if (last_ss_low != 34) begin errors++; $display("FAIL loop_ss_low got %0d want 34", last_ss_low); end
  endtask

  task automatic test_slave();
    bit ok;
    miso_mode = 1; data_to_send = 8'hC3;
    bus1.tx_data = 8'h3C; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL slave_done_timeout got 0 want 1"); end
    checks++; if (s_rx !== 8'h3C) begin errors++; $display("FAIL slave_received got %h want 3c", s_rx); end
    checks++; if (miso_bits !== 8'hC3) begin errors++; $display("FAIL slave_miso_stream got %h want c3", miso_bits); end
    checks++; if (bus1.rx_data !== miso_bits) begin errors++; $display("FAIL slave_master_rx got %h want %h", bus1.rx_data, miso_bits); end
    tick();
    miso_mode = 0;
  endtask

  task automatic test_start_ignored();
    int cnt, r0, d0;
    miso_mode = 0;
    cnt = 0;
    r0 = sclk_rises; d0 = done_cnt;
    bus1.tx_data = 8'h5A; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int i = 0; i < 200 && !bus1.done; i++) begin
      if (bus1.busy) cnt++;
      bus1.start = bus1.busy && (cnt == 1 || cnt == 10 || cnt == 33);
      if (bus1.start) bus1.tx_data = 8'hFF;
      tick();
    end
    bus1.start = 1'b0;
    checks++; if (bus1.done !== 1'b1) begin errors++; $display("FAIL ign_done_timeout got 0 want 1"); end
    checks++; if (cnt != 34) begin errors++; $display("FAIL ign_busy_len got %0d want 34", cnt); end
    checks++; if (bus1.rx_data !== 8'h5A) begin errors++; $display("FAIL ign_rx got %h want 5a", bus1.rx_data); end
    repeat (10) tick();
    checks++; if (sclk_rises - r0 != 8) begin errors++; $display("FAIL ign_rises got %0d want 8", sclk_rises - r0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ign_done_cnt got %0d want 1", done_cnt - d0); end
    checks++; if (bus1.busy !== 1'b0 || bus1.SS !== 1'b1) begin
      errors++; $display("FAIL ign_idle got busy=%b ss=%b want busy=0 ss=1", bus1.busy, bus1.SS);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int rises, d0;
    logic p;
    miso_mode = 0;
    bus1.tx_data = 8'h00; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    wait_done(100, ok);
    checks++; if (!ok || bus1.rx_data !== 8'h00) begin
      errors++; $display("FAIL rst_prior_rx got %h want 00", bus1.rx_data);
    end
    tick();
    bus1.tx_data = 8'hFF; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    rises = 0; p = bus1.SCLK;
    for (int i = 0; i < 200 && rises < 4; i++) begin
      tick();
      if (bus1.SCLK && !p) rises++;
      p = bus1.SCLK;
    end
    checks++; if (rises != 4) begin errors++; $display("FAIL rst_reach_rise4 got %0d want 4", rises); end
    d0 = done_cnt;
    RESET = 1'b1;
    tick();
    checks++; if (bus1.SS !== 1'b1 || bus1.SCLK !== 1'b0 || bus1.MOSI !== 1'b0 || bus1.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs got ss=%b sclk=%b mosi=%b busy=%b want 1 0 0 0",
               bus1.SS, bus1.SCLK, bus1.MOSI, bus1.busy);
    end
    checks++; if (bus1.rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rx got %h want 00", bus1.rx_data); end
    RESET = 1'b0;
    repeat (20) tick();
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL rst_mid_no_done got %0d want 0", done_cnt - d0); end
    checks++; if (bus1.SS !== 1'b1) begin errors++; $display("FAIL rst_mid_ss_stays got %b want 1", bus1.SS); end
  endtask

  task automatic test_div1();
    int cnt;
    cnt = 0;
    bus2.tx_data = 8'h01; bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int i = 0; i < 100 && !bus2.done; i++) begin
      if (!bus2.SS) cnt++;
      tick();
    end
    checks++; if (bus2.done !== 1'b1) begin errors++; $display("FAIL div1_done_timeout got 0 want 1"); end
    checks++; if (cnt != 17) begin errors++; $display("FAIL div1_ss_low got %0d want 17", cnt); end
    checks++; if (bus2.rx_data !== 8'hFF) begin errors++; $display("FAIL div1_rx got %h want ff", bus2.rx_data); end
    tick();
  endtask

`ifdef SPI_MASTER_BURST_EN
  task automatic test_burst();
    bit ok;
    int qs, s0, d0;
    miso_mode = 0;
    qs = done_rx_q.size(); s0 = ss_rises; d0 = done_cnt;
    bus1.tx_data = 8'h12; bus1.start = 1'b1;
    tick();
    bus1.tx_data = 8'h34;
    wait_done(100, ok);
    bus1.start = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL burst_first_timeout got 0 want 1"); end
    checks++; if (bus1.SS !== 1'b0) begin errors++; $display("FAIL burst_ss_held got %b want 0", bus1.SS); end
    tick();
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_second_timeout got 0 want 1"); end
    tick();
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL burst_done_cnt got %0d want 2", done_cnt - d0); end
    checks++; if (done_rx_q.size() < qs + 2 || done_rx_q[qs] !== 8'h12 || done_rx_q[qs+1] !== 8'h34) begin
      errors++; $display("FAIL burst_rx_seq got %0d entries want 12,34", done_rx_q.size() - qs);
    end
    checks++; if (ss_rises - s0 != 1) begin errors++; $display("FAIL burst_ss_rises got %0d want 1", ss_rises - s0); end
    checks++; if (last_ss_low != 68) begin errors++; $display("FAIL burst_ss_low got %0d want 68", last_ss_low); end
  endtask
`else
  task automatic test_no_burst();
    bit ok;
    int s0;
    miso_mode = 0;
    s0 = ss_rises;
    bus1.tx_data = 8'h12; bus1.start = 1'b1;
    tick();
    bus1.tx_data = 8'h34;
    wait_done(100, ok);
    checks++; if (!ok || bus1.SS !== 1'b1) begin
      errors++; $display("FAIL noburst_ss_release got %b want 1", bus1.SS);
    end
    tick();
    bus1.start = 1'b0;
    checks++; if (bus1.SS !== 1'b0) begin errors++; $display("FAIL noburst_gap got %b want 0", bus1.SS); end
    wait_done(100, ok);
    checks++; if (!ok || bus1.rx_data !== 8'h34) begin
      errors++; $display("FAIL noburst_rx got %h want 34", bus1.rx_data);
    end
    tick();
    checks++; if (ss_rises - s0 != 2) begin errors++; $display("FAIL noburst_ss_rises got %0d want 2", ss_rises - s0); end
  endtask
`endif

  task automatic test_mosi_timing();
    checks++; if (mosi_viol != 0) begin errors++; $display("FAIL mosi_while_sclk_high got %0d want 0", mosi_viol); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_start_ignored();
    test_div1();
`ifdef SPI_MASTER_BURST_EN
    test_burst();
`else
    test_no_burst();
`endif
    test_mosi_timing();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-clock SPI master, mode 0 (CPOL=0, CPHA=0), MSB first. It is the initiator matching the team's existing SPI slave.
- Generates SCLK, SS and MOSI from the system clock and captures MISO.
- Exchanges one DATA_WIDTH-bit word per start request.
- Sits between on-chip control logic and an external or on-die SPI slave, and doubles as the bench driver for slave verification.

Parameters:
- DATA_WIDTH, 8: bits per transfer. Minimum 2.
- CLK_DIV, 2: CLK cycles per SCLK half-period. Minimum 1.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  transfer request, sampled when idle.
- tx_data  input  DATA_WIDTH  word to send; latched on the accepted start.
- rx_data  output  DATA_WIDTH  last received word; updated with done.
- busy  output  1  high from the cycle after start acceptance until transfer end.
- done  output  1  one-cycle pulse when rx_data is updated.
- SCLK  output  1  SPI clock, idles low.
- SS  output  1  slave select, active low, idles high.
- MOSI  output  1  serial data to slave.
- MISO  input  1  serial data from slave; used unsynchronised (slave is timed by SCLK).

Behaviour:
- All outputs are registered.
- Reset values: SCLK=0, SS=1, MOSI=0, busy=0, done=0, rx_data=0. Internal shift registers, bit counter and divide counter are cleared; state=IDLE.
- Reset mid-transfer: the next edge forces the reset values. No done pulse.
- IDLE:
  - On start=1: latch tx_data into tx_shift, clear div_cnt and bit_cnt.
  - Next cycle: SS=0, MOSI=tx_data[MSB], busy=1; go to LEAD.
  - start=0: hold.
- LEAD: after CLK_DIV cycles, drive SCLK=1, shift MISO into rx_shift LSB, go to HIGH.
- HIGH: after CLK_DIV cycles, drive SCLK=0.
  - If bit_cnt==DATA_WIDTH-1: go to TRAIL.
  - Else: shift tx_shift left, MOSI=next bit, bit_cnt+1, go to LOW.
- LOW: after CLK_DIV cycles, drive SCLK=1, sample MISO into rx_shift, go to HIGH.
- TRAIL: after CLK_DIV cycles:
  - drive SS=1 and busy=0, MOSI=0;
  - rx_data<=rx_shift and done=1 for exactly one cycle;
  - go to IDLE.
- Timing:
  - SS stays low for exactly (2*DATA_WIDTH+1)*CLK_DIV cycles.
  - Exactly DATA_WIDTH rising SCLK edges occur per transfer.
  - MOSI changes only while SCLK is low, or at SS fall.
  - MISO is sampled in the same CLK cycle that SCLK is driven high.
- start while busy: ignored. tx_data changes after acceptance have no effect.
- Minimum SS-high gap between transfers: 1 CLK cycle (IDLE visit).
- div_cnt wraps at CLK_DIV-1. bit_cnt has width $clog2(DATA_WIDTH) and never wraps within a transfer.

Optional Feature:
- Macro: SPI_MASTER_BURST_EN.
- Defined:
  - If start=1 in the final TRAIL cycle, the transfer continues without releasing SS:
    - latch tx_data, clear counters, MOSI=new MSB;
    - go to LEAD with SS held 0 and busy held 1;
    - done and rx_data update exactly as normal for the finished word.
  - A burst of N words keeps SS low for N*(2*DATA_WIDTH+1)*CLK_DIV cycles.
- Undefined: start in TRAIL is ignored and SS always returns high.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum {IDLE, LEAD, HIGH, LOW, TRAIL};
  - SPI_CPOL=0 and SPI_CPHA=0 mode constants;
  - a default data width constant shared with the slave.
- One natural sub-module: spi_master_clkgen. It contains the CLK_DIV half-period counter and outputs a one-cycle tick. It is cleared on start acceptance and on RESET.

Test Plan:
- Loopback (MISO tied to MOSI), CLK_DIV=2, tx_data=0xA5:
  - MOSI bits 1,0,1,0,0,1,0,1 are valid at each SCLK rise;
  - rx_data=0xA5 with one done pulse;
  - SS low exactly 34 cycles.
- Against the slave model:
  - master sends 0x3C; slave data_to_send=0xC3;
  - slave received_data=0x3C;
  - master rx_data equals the slave's MISO bit stream (checked bit by bit against the model).
- start pulsed again at busy cycles 1, 10 and 33:
  - ignored;
  - exactly 8 SCLK rises per transfer;
  - one done per accepted start.
- RESET asserted at SCLK rise 4 of 0xFF:
  - the next edge gives SS=1, SCLK=0, MOSI=0, busy=0;
  - no done; rx_data stays at its prior value.
- CLK_DIV=1, tx_data=0x01, MISO held 1:
  - SS low 17 cycles;
  - rx_data=0xFF.
- With SPI_MASTER_BURST_EN, start held high over two transfers (0x12, 0x34):
  - SS never rises between words;
  - two done pulses, rx_data sequence matches loopback;
  - SS low 68 cycles at CLK_DIV=2.
